// File: rtl/div_pkg.sv
// Shared definitions for the signed 32/16 restoring divider.
package div_pkg;

   localparam int DIVIDEND_W = 32;
   localparam int DIVISOR_W  = 16;
   localparam int ITER       = 32;

   localparam logic [31:0] QUOT_DIV0 = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_tc_32_16_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step
   import div_pkg::*;
(
   input  logic [DIVISOR_W:0]   i_rem,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_dvsr,
   output logic [DIVISOR_W:0]   o_rem,
   output logic                 o_qbit
);

   // The partial remainder stays below |divisor| <= 2^15, so the shifted
   // value fits in 17 bits and bit 17 of the difference is a true sign bit.
   logic [DIVISOR_W+1:0] w_diff;

   // Trial subtraction and restore selection.
   always_comb begin
      w_diff = {i_rem, i_bit} - {2'b00, i_dvsr};
      o_qbit = ~w_diff[DIVISOR_W+1];
      o_rem  = o_qbit ? w_diff[DIVISOR_W:0] : {i_rem[DIVISOR_W-1:0], i_bit};
   end

endmodule

// File: rtl/div_tc_32_16.sv
// Sequential signed divider, 32-bit dividend by 16-bit divisor.
// Radix-2 restoring division on magnitudes, one quotient bit per cycle,
// followed by a single sign-fix cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and the result registers hold steady until the out_valid & out_ready edge.
module div_tc_32_16 #(
   parameter int DIVIDEND_W = 32,
   parameter int DIVISOR_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  overflow,
   output logic [1:0]            o_dbg_state
);

   import div_pkg::*;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [4:0]              r_cnt;
   logic [DIVIDEND_W-1:0]   r_dvd;        // dividend magnitude in, quotient bits out
   logic [DIVISOR_W-1:0]    r_dvsr;       // divisor magnitude
   logic [DIVISOR_W:0]      r_rem;        // partial remainder
   logic                    r_neg_dvd;
   logic                    r_neg_dvsr;
   logic                    r_div0;
   logic                    r_ovf;
   logic [DIVISOR_W-1:0]    r_dvd_lo;     // raw low dividend bits for the div-by-zero remainder
   logic [DIVIDEND_W-1:0]   r_quot;
   logic [DIVISOR_W-1:0]    r_remo;
   logic                    r_dbz;
   logic                    r_ov;

   logic                    w_accept;
   logic [DIVISOR_W:0]      w_rem_next;
   logic                    w_qbit;
   logic [DIVIDEND_W-1:0]   w_dvd_mag;
   logic [DIVISOR_W-1:0]    w_dvsr_mag;

   div_step u_step (
      .i_rem  (r_rem),
      .i_bit  (r_dvd[DIVIDEND_W-1]),
      .i_dvsr (r_dvsr),
      .o_rem  (w_rem_next),
      .o_qbit (w_qbit)
   );

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign quotient    = r_quot;
   assign remainder   = r_remo;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ov;
   assign o_dbg_state = r_state;
   assign w_accept    = in_valid & in_ready;

   // Operand magnitudes; |-2^31| = 2^31 is representable as 32-bit unsigned.
   always_comb begin
      w_dvd_mag  = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
      w_dvsr_mag = divisor[DIVISOR_W-1]   ? (~divisor + 1'b1)  : divisor;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (in_valid)                  w_state_next = CALC;
         CALC: if (r_cnt == 5'(ITER - 1))     w_state_next = FIX;
         FIX:                                 w_state_next = DONE;
         DONE: if (out_ready)                 w_state_next = IDLE;
         default:                             w_state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_dvsr     <= '0;
         r_rem      <= '0;
         r_neg_dvd  <= 1'b0;
         r_neg_dvsr <= 1'b0;
         r_div0     <= 1'b0;
         r_ovf      <= 1'b0;
         r_dvd_lo   <= '0;
         r_quot     <= '0;
         r_remo     <= '0;
         r_dbz      <= 1'b0;
         r_ov       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cnt      <= '0;
                  r_dvd      <= w_dvd_mag;
                  r_dvsr     <= w_dvsr_mag;
                  r_rem      <= '0;
                  r_neg_dvd  <= dividend[DIVIDEND_W-1];
                  r_neg_dvsr <= divisor[DIVISOR_W-1];
                  r_div0     <= (divisor == '0);
                  r_ovf      <= (dividend == INT_MIN) && (divisor == '1);
                  r_dvd_lo   <= dividend[DIVISOR_W-1:0];
               end
            end
            CALC: begin
               r_rem <= w_rem_next;
               r_dvd <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
               r_cnt <= r_cnt + 5'd1;
            end
            FIX: begin
               // -2^31 / -1 already yields 2^31 from the magnitude path with
               // no negation; it is forced anyway so the flag and value agree.
               if (r_div0) begin
                  r_quot <= QUOT_DIV0;
                  r_remo <= r_dvd_lo;
               end else if (r_ovf) begin
                  r_quot <= INT_MIN;
                  r_remo <= '0;
               end else begin
                  r_quot <= (r_neg_dvd ^ r_neg_dvsr) ? (~r_dvd + 1'b1) : r_dvd;
                  r_remo <= r_neg_dvd ? (~r_rem[DIVISOR_W-1:0] + 1'b1)
                                      : r_rem[DIVISOR_W-1:0];
               end
               r_dbz <= r_div0;
               r_ov  <= r_ovf & ~r_div0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
